// File: rtl/bus_interface_pkg.sv
// Shared definitions for the external multiplexed-bus responder: FSM state
// encodings, read/write polarity and the data value returned on a timeout.
package bus_interface_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_ADDR_HI = 2'd1,
    BUS_ADDR_LO = 2'd2,
    BUS_DATA    = 2'd3
  } bus_state_e;

  // Polarity of req_rw and of the external rw_n pin.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Read data reported when memory never asserts ext_ready.
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/bus_wait_timer.sv
// Data-phase wait counter: cleared before the data phase, incremented on each
// ext_ready-low cycle, saturating at WAIT_MAX so it never wraps.
module bus_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // A zero WAIT_MAX still needs a one-bit counter to be legal.
  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(WAIT_MAX));

  // Clear takes priority; increment holds once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_interface.sv
// Responder for decoder memory requests. Serialises one 16-bit address and a
// byte of data onto the 8-bit multiplexed external bus in up to three phases
// (address-high, address-low, data), skipping the high phase when the page
// byte matches the one last latched by the external address-high register.
//
// Handshake: req_valid is sampled only on a rising edge where rdy=1; that
// edge accepts the request and latches req_addr/req_rw/req_wdata. rdy stays
// low until the transfer ends, and any req_valid seen while rdy=0 is ignored.
module bus_interface
  import bus_interface_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int SKIP_HI  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rdy,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in,
  output logic        ale_hi,
  output logic        ale_lo,
  output logic        rw_n,
  input  logic        ext_ready,
  output logic [1:0]  state_dbg
);

  bus_state_e  state_q, state_d;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  cache_hi_q;
  logic        cache_valid_q;
  logic        expired;
  logic        accept;
  logic        page_hit;
  logic        xfer_done;
  logic        xfer_timeout;

  assign rdy          = (state_q == BUS_IDLE);
  assign state_dbg    = state_q;
  assign accept       = rdy && req_valid;
  assign page_hit     = (SKIP_HI != 0) && cache_valid_q &&
                        (req_addr[15:8] == cache_hi_q);
  assign xfer_done    = (state_q == BUS_DATA) && ext_ready;
  assign xfer_timeout = (state_q == BUS_DATA) && !ext_ready && expired;

  bus_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == BUS_ADDR_LO),
    .inc     ((state_q == BUS_DATA) && !ext_ready),
    .expired (expired)
  );

  // State register; reset returns to IDLE so the bus is released at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus pin decode; all pins are pure functions of state so
  // each phase drives a constant bus_oe and a single-cycle strobe.
  always_comb begin
    state_d = state_q;
    bus_out = 8'h00;
    bus_oe  = 1'b0;
    ale_hi  = 1'b0;
    ale_lo  = 1'b0;
    rw_n    = RW_READ;
    case (state_q)
      BUS_IDLE: begin
        if (req_valid) begin
          state_d = page_hit ? BUS_ADDR_LO : BUS_ADDR_HI;
        end
      end
      BUS_ADDR_HI: begin
        bus_out = addr_q[15:8];
        bus_oe  = 1'b1;
        ale_hi  = 1'b1;
        state_d = BUS_ADDR_LO;
      end
      BUS_ADDR_LO: begin
        bus_out = addr_q[7:0];
        bus_oe  = 1'b1;
        ale_lo  = 1'b1;
        state_d = BUS_DATA;
      end
      BUS_DATA: begin
        rw_n = rw_q;
        if (rw_q == RW_WRITE) begin
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end
        if (ext_ready || expired) begin
          state_d = BUS_IDLE;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // Request capture on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 16'h0000;
      rw_q    <= RW_READ;
      wdata_q <= 8'h00;
    end else if (accept) begin
      addr_q  <= req_addr;
      rw_q    <= req_rw;
      wdata_q <= req_wdata;
    end
  end

  // Page cache mirrors the external high-address latch; a timeout leaves
  // the external side in an unknown condition, so the cache is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_hi_q    <= 8'h00;
      cache_valid_q <= 1'b0;
    end else if (xfer_timeout) begin
      cache_valid_q <= 1'b0;
    end else if (state_q == BUS_ADDR_HI) begin
      cache_hi_q    <= addr_q[15:8];
      cache_valid_q <= 1'b1;
    end
  end

  // Completion results, registered so the pulses land in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= (xfer_done || xfer_timeout) && (rw_q == RW_READ);
      bus_err     <= xfer_timeout;
      if (rw_q == RW_READ) begin
        if (xfer_done) begin
          rdata <= bus_in;
        end else if (xfer_timeout) begin
          rdata <= TIMEOUT_FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
// Self-checking bench for bus_interface: a vector table of transactions with
// explicit expectations, a hand-written mid-transfer reset sequence and a
// short randomised run, with read data checked through an expected queue.
module tb_bus_interface;

  localparam int WAIT_MAX = 15;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rdy;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [7:0]  bus_in;
  logic        ale_hi;
  logic        ale_lo;
  logic        rw_n;
  logic        ext_ready;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // Bench-side page model, used for the randomised run.
  logic       model_valid = 1'b0;
  logic [7:0] model_hi    = 8'h00;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  bin;
    int          waits;
    logic        exp_hi;
  } vec_t;

  vec_t vecs[8];

  bus_interface #(
    .WAIT_MAX (WAIT_MAX),
    .SKIP_HI  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rdy         (rdy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .bus_err     (bus_err),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .bus_in      (bus_in),
    .ale_hi      (ale_hi),
    .ale_lo      (ale_lo),
    .rw_n        (rw_n),
    .ext_ready   (ext_ready),
    .state_dbg   (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one transfer, observe every phase, then check the completion cycle.
  task automatic do_txn(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                        input logic [7:0] bi, input int waits, input logic exp_hi);
    logic       saw_hi, saw_lo, in_data, bad_data, bad_excl, exp_err;
    logic [7:0] hi_b, lo_b;
    int         lat, k, exp_lat, guard;
    saw_hi = 0; saw_lo = 0; in_data = 0; bad_data = 0; bad_excl = 0;
    hi_b = 0; lo_b = 0; k = 0;
    exp_err = (waits > WAIT_MAX);
    exp_lat = (exp_hi ? 4 : 3) + (exp_err ? WAIT_MAX : waits);
    if (rw) exp_q.push_back(exp_err ? 8'hFF : bi);
    guard = 0;
    while (!rdy && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    ext_ready = 1'b0; bus_in = 8'h00;
    @(posedge clk); #1;
    lat = 1;
    // Scramble the request inputs so the DUT must use its latched copy.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_rw = ~rw;
    while (!rdy && lat < 80) begin
      if (ale_hi && ale_lo) bad_excl = 1;
      if (ale_hi) begin saw_hi = 1; hi_b = bus_out; end
      if (ale_lo) begin
        saw_lo = 1; lo_b = bus_out; in_data = 1;
      end else if (in_data) begin
        if (rw) begin
          if (rw_n !== 1'b1 || bus_oe !== 1'b0) bad_data = 1;
        end else begin
          if (rw_n !== 1'b0 || bus_oe !== 1'b1 || bus_out !== wd) bad_data = 1;
        end
        ext_ready = (k >= waits);
        bus_in    = (k >= waits) ? bi : ~bi;
        k++;
      end
      @(posedge clk); #1;
      lat++;
    end
    ext_ready = 1'b1;
    chk("rdy_bound", {31'd0, rdy}, 32'd1);
    chk("ale_hi_seen", {31'd0, saw_hi}, {31'd0, exp_hi});
    if (exp_hi) chk("hi_byte", {24'd0, hi_b}, {24'd0, addr[15:8]});
    chk("ale_lo_seen", {31'd0, saw_lo}, 32'd1);
    chk("lo_byte", {24'd0, lo_b}, {24'd0, addr[7:0]});
    chk("data_phase_pins", {31'd0, bad_data}, 32'd0);
    chk("strobe_excl", {31'd0, bad_excl}, 32'd0);
    chk("latency", lat, exp_lat);
    chk("idle_pins", {23'd0, bus_oe, ale_hi, ale_lo, rw_n, bus_out}, {23'd0, 4'b0001, 8'h00});
    chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, rw});
    chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    if (rdata_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        chk("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
      end
    end else if (rw && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
    if (exp_err) model_valid = 1'b0;
    else begin model_valid = 1'b1; model_hi = addr[15:8]; end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b1, 8'h00, 8'hA5, 0,  1'b1};  // cold read
    vecs[1] = '{16'h12FF, 1'b0, 8'h3C, 8'h00, 0,  1'b0};  // same-page write
    vecs[2] = '{16'h00FF, 1'b1, 8'h00, 8'h5A, 0,  1'b1};  // page 00
    vecs[3] = '{16'h0100, 1'b0, 8'h77, 8'h00, 0,  1'b1};  // page change to 01
    vecs[4] = '{16'h0142, 1'b1, 8'h00, 8'hC3, 5,  1'b0};  // wait stretch
    vecs[5] = '{16'h0155, 1'b1, 8'h00, 8'h66, 20, 1'b0};  // timeout
    vecs[6] = '{16'h0160, 1'b1, 8'h00, 8'h99, 0,  1'b1};  // cache dropped
    vecs[7] = '{16'h0161, 1'b0, 8'hE1, 8'h00, 15, 1'b0};  // longest legal wait

    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b1; req_addr = 16'h0;
    req_wdata = 8'h0; bus_in = 8'h0; ext_ready = 1'b1;
    #12;
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
    chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
    chk("rst_strobes", {30'd0, ale_hi, ale_lo}, 32'd0);
    chk("rst_rw_n", {31'd0, rw_n}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].bin,
             vecs[i].waits, vecs[i].exp_hi);
    end

    // Reset while in ADDR_LO: bus must drop at once, with no completion pulse.
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h2000; ext_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_addr_hi", {31'd0, ale_hi}, 32'd1);
    @(posedge clk); #1;
    chk("mid_addr_lo", {31'd0, ale_lo}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", {31'd0, bus_oe}, 32'd0);
    chk("mid_rst_strobes", {30'd0, ale_hi, ale_lo}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_pulse", {30'd0, rdata_valid, bus_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rdy", {31'd0, rdy}, 32'd1);
    chk("mid_rst_no_pulse2", {30'd0, rdata_valid, bus_err}, 32'd0);
    do_txn(16'h2010, 1'b1, 8'h00, 8'h4B, 0, 1'b1);

    // Randomised run across two pages, expectations from the page model.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      logic        r, h;
      a = {7'h18, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
      r = 1'($urandom_range(0, 1));
      h = !(model_valid && (a[15:8] == model_hi));
      do_txn(a, r, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 254)),
             $urandom_range(0, 3), h);
    end

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
